// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encoding and normalised button levels.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_REL = 2'b00,
    WAIT_PRS = 2'b01,
    IDLE_PRS = 2'b10,
    WAIT_REL = 2'b11
  } state_t;

  localparam logic BTN_PRESSED  = 1'b1;
  localparam logic BTN_RELEASED = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports: i_clk, i_rst_n (async active-low), i_d (async in), o_q (synced out).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: pad -> 2FF sync -> stability FSM -> start_clean.
// Ports: clk, reset (async active-low), btn_raw (pad), start_clean (1=pressed),
// press_pulse (one-cycle press strobe, present only with BTN_EDGE_PULSE_EN).
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
`ifdef BTN_EDGE_PULSE_EN
  output logic press_pulse,
`endif
  output logic start_clean
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES);

  // Unpressed pad level, so reset never looks like a press.
  localparam logic PAD_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic                 w_pad_sync;
  logic                 w_btn_s;
  logic                 w_done;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_clean;
  logic                 w_clean_nxt;
  logic                 w_rise;

  sync_2ff #(
    .RESET_VAL (PAD_IDLE)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (btn_raw),
    .o_q     (w_pad_sync)
  );

  assign w_btn_s = ACTIVE_LOW ? ~w_pad_sync : w_pad_sync;

  // >= rather than == lets DEBOUNCE_CYCLES==1 accept after one
  // WAIT cycle, since WAIT is always entered with the count at 1.
  assign w_done = (r_cnt >= CNT_LAST);

  // Saturating increment: the count never wraps back to zero.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt
                                        : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    w_rise      = 1'b0;
    case (r_state)
      IDLE_REL: begin
        w_cnt_nxt = '0;
        if (w_btn_s == BTN_PRESSED) begin
          w_state_nxt = WAIT_PRS;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      WAIT_PRS: begin
        if (w_btn_s != BTN_PRESSED) begin
          w_state_nxt = IDLE_REL;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = IDLE_PRS;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b1;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      IDLE_PRS: begin
        w_cnt_nxt = '0;
        if (w_btn_s == BTN_RELEASED) begin
          w_state_nxt = WAIT_REL;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      WAIT_REL: begin
        if (w_btn_s != BTN_RELEASED) begin
          w_state_nxt = IDLE_PRS;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = IDLE_REL;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE_REL;
        w_cnt_nxt   = '0;
        w_clean_nxt = 1'b0;
      end
    endcase
  end

`ifdef BTN_EDGE_PULSE_EN
  logic r_pulse;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE_REL;
      r_cnt   <= '0;
      r_clean <= 1'b0;
`ifdef BTN_EDGE_PULSE_EN
      r_pulse <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
`ifdef BTN_EDGE_PULSE_EN
      r_pulse <= w_rise;
`endif
    end
  end

  assign start_clean = r_clean;

`ifdef BTN_EDGE_PULSE_EN
  assign press_pulse = r_pulse;
`else
  // Rise strobe has no consumer without the pulse output.
  logic w_unused;
  assign w_unused = w_rise;
`endif

endmodule
